execute_md: RTL and testbench

Parametrised execute stage for the risc-v-lite pipeline. It sits between the ID/EX and EX/MEM boundaries. It resolves branches and jumps, applies operand forwarding, drives the shared `ALU`, and owns the EX/MEM pipeline register. It adds an iterative RV32M multiply/divide unit: the stage stalls the upstream pipeline and injects bubbles into MEM until the M-type result is ready.

---
 rtl/exe_pkg.sv | 60 ++++++
 rtl/ALU.sv | 40 ++++
 rtl/muldiv_iter.sv | 139 +++++++++++++
 rtl/register_generic.sv | 19 +
 rtl/execute_md.sv | 123 ++++++++++++
 tb/tb_execute_md.sv | 202 ++++++++++++++++++++
 6 files changed

// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: control-word layout, branch codes,
// forwarding selects, ALU op codes and the M-unit op/state types.
package exe_pkg;

   localparam int CW_W      = 13;
   localparam int CW_SELB   = 12;
   localparam int CW_SELA   = 11;
   localparam int CW_BR_HI  = 10;
   localparam int CW_BR_LO  = 8;
   localparam int CW_JMP    = 7;
   localparam int CW_MEM_HI = 6;
   localparam int CW_MEM_W  = 7;

   localparam logic [2:0] BR_NONE = 3'b000;
   localparam logic [2:0] BR_EQ   = 3'b001;
   localparam logic [2:0] BR_NE   = 3'b010;
   localparam logic [2:0] BR_LE   = 3'b011;
   localparam logic [2:0] BR_LT   = 3'b100;
   localparam logic [2:0] BR_GE   = 3'b101;
   localparam logic [2:0] BR_LTU  = 3'b110;
   localparam logic [2:0] BR_GEU  = 3'b111;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_MUX = 2'b01;
   localparam logic [1:0] FWD_ALU = 2'b10;

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_AND   = 4'd2;
   localparam logic [3:0] ALU_OR    = 4'd3;
   localparam logic [3:0] ALU_XOR   = 4'd4;
   localparam logic [3:0] ALU_SLL   = 4'd5;
   localparam logic [3:0] ALU_SRL   = 4'd6;
   localparam logic [3:0] ALU_SRA   = 4'd7;
   localparam logic [3:0] ALU_SLT   = 4'd8;
   localparam logic [3:0] ALU_SLTU  = 4'd9;
   localparam logic [3:0] ALU_PASSB = 4'd10;

   typedef enum logic [2:0] {
      MD_MUL    = 3'b000,
      MD_MULH   = 3'b001,
      MD_MULHSU = 3'b010,
      MD_MULHU  = 3'b011,
      MD_DIV    = 3'b100,
      MD_DIVU   = 3'b101,
      MD_REM    = 3'b110,
      MD_REMU   = 3'b111
   } md_op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'b00,
      MD_BUSY = 2'b01,
      MD_DONE = 2'b10
   } md_state_e;

   function automatic logic is_mul_op(input md_op_e op);
      return ~op[2];
   endfunction

endpackage

// File: rtl/ALU.sv
// Shared integer ALU used by the execute stage; purely combinational.
module ALU
   import exe_pkg::*;
#(
   parameter int N = 32
) (
   input  logic [3:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] res
);

   localparam int SH_W = $clog2(N);

   logic signed [N-1:0] a_s, b_s;
   logic [SH_W-1:0]     sh;

   assign a_s = a;
   assign b_s = b;
   assign sh  = b[SH_W-1:0];

   always_comb begin
      res = '0;
      case (op)
         ALU_ADD:   res = a + b;
         ALU_SUB:   res = a - b;
         ALU_AND:   res = a & b;
         ALU_OR:    res = a | b;
         ALU_XOR:   res = a ^ b;
         ALU_SLL:   res = a << sh;
         ALU_SRL:   res = a >> sh;
         ALU_SRA:   res = a_s >>> sh;
         ALU_SLT:   res = {{(N-1){1'b0}}, (a_s < b_s)};
         ALU_SLTU:  res = {{(N-1){1'b0}}, (a < b)};
         ALU_PASSB: res = b;
         default:   res = '0;
      endcase
   end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV32M unit: radix-2 shift-add multiply and restoring divide on
// operand magnitudes. EXE_FAST_MUL_EN swaps the multiply loop for one N x N product.
module muldiv_iter
   import exe_pkg::*;
#(
   parameter int N        = 32,
   parameter int MD_CNT_W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         pipe_en,
   input  logic [2:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         done,
   output logic [N-1:0] result
);

`ifdef EXE_FAST_MUL_EN
   localparam bit FAST_MUL = 1'b1;
`else
   localparam bit FAST_MUL = 1'b0;
`endif

   md_state_e           state_q, state_d;
   logic [MD_CNT_W-1:0] cnt_q;
   md_op_e              op_e, op_q;
   logic [N-1:0]        a_q, b_q, acc_q, sh_q;
   logic                neg_q, rem_neg_q, div_zero_q;
   logic                a_sgn, b_sgn, a_neg, b_neg;
   logic [N-1:0]        a_mag, b_mag;
   logic [N:0]          add_sum, div_shift;
   logic                div_ge;
   logic [N-1:0]        div_sub;
   logic [2*N-1:0]      prod, prod_fix;
   logic [N-1:0]        quo, rem;

   function automatic logic [N-1:0] neg_if(input logic [N-1:0] v, input logic n);
      return n ? -v : v;
   endfunction

   assign op_e = md_op_e'(op);

   always_comb begin
      a_sgn = 1'b0;
      b_sgn = 1'b0;
      case (op_e)
         MD_MULH, MD_DIV, MD_REM: begin
            a_sgn = 1'b1;
            b_sgn = 1'b1;
         end
         MD_MULHSU: a_sgn = 1'b1;
         default: ;
      endcase
   end

   assign a_neg = a_sgn & a[N-1];
   assign b_neg = b_sgn & b[N-1];
   assign a_mag = neg_if(a, a_neg);
   assign b_mag = neg_if(b, b_neg);

   always_comb begin
      state_d = state_q;
      case (state_q)
         MD_IDLE: if (start) state_d = (FAST_MUL && is_mul_op(op_e)) ? MD_DONE : MD_BUSY;
         MD_BUSY: if (cnt_q == '0) state_d = MD_DONE;
         MD_DONE: if (pipe_en) state_d = MD_IDLE;
         default: state_d = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= MD_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == MD_IDLE && start)
            cnt_q <= MD_CNT_W'(N - 1);
         else if (state_q == MD_BUSY && cnt_q != '0)
            cnt_q <= cnt_q - MD_CNT_W'(1);
      end
   end

   // iteration step: acc is product-high / partial remainder, sh is multiplier / quotient
   assign add_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, a_q} : '0);
   assign div_shift = {acc_q, sh_q[N-1]};
   assign div_ge    = div_shift >= {1'b0, b_q};
   assign div_sub   = div_shift[N-1:0] - b_q;

   always_ff @(posedge clk) begin
      if (state_q == MD_IDLE && start) begin
         a_q        <= a_mag;
         b_q        <= b_mag;
         op_q       <= op_e;
         neg_q      <= a_neg ^ b_neg;
         rem_neg_q  <= a_neg;
         div_zero_q <= (b == '0);
         acc_q      <= '0;
         sh_q       <= is_mul_op(op_e) ? b_mag : a_mag;
      end else if (state_q == MD_BUSY) begin
         if (is_mul_op(op_q)) begin
            {acc_q, sh_q} <= {add_sum, sh_q[N-1:1]};
         end else if (div_ge) begin
            acc_q <= div_sub;
            sh_q  <= {sh_q[N-2:0], 1'b1};
         end else begin
            acc_q <= div_shift[N-1:0];
            sh_q  <= {sh_q[N-2:0], 1'b0};
         end
      end
   end

`ifdef EXE_FAST_MUL_EN
   assign prod = {{N{1'b0}}, a_q} * {{N{1'b0}}, b_q};
`else
   assign prod = {acc_q, sh_q};
`endif

   // overflow (-2^(N-1) / -1) falls out of the magnitude path; only x/0 needs an override
   assign prod_fix = neg_q ? -prod : prod;
   assign quo      = div_zero_q ? '1 : neg_if(sh_q, neg_q);
   assign rem      = neg_if(acc_q, rem_neg_q);

   always_comb begin
      result = '0;
      case (op_q)
         MD_MUL:                       result = prod_fix[N-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU: result = prod_fix[2*N-1:N];
         MD_DIV, MD_DIVU:              result = quo;
         MD_REM, MD_REMU:              result = rem;
         default:                      result = '0;
      endcase
   end

   assign done = (state_q == MD_DONE);

endmodule

// File: rtl/register_generic.sv
// Enable-gated register with asynchronous active-low clear.
module register_generic #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         q <= '0;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/execute_md.sv
// risc-v-lite execute stage: forwarding, branch resolve, ALU, RV32M unit and the
// EX/MEM register. Optional single-cycle multiply with EXE_FAST_MUL_EN.
module execute_md
   import exe_pkg::*;
#(
   parameter int N        = 32,
   parameter int MD_CNT_W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         pipe_en,
   input  logic [12:0]  cwEX,
   input  logic [3:0]   aluOp,
   input  logic         md_valid,
   input  logic [2:0]   mdOp,
   input  logic [4:0]   Rdest_in,
   input  logic [N-1:0] NPCin,
   input  logic [N-1:0] NPC4_IN,
   input  logic [N-1:0] r1,
   input  logic [N-1:0] r2,
   input  logic [N-1:0] Imm,
   input  logic [1:0]   forwardA,
   input  logic [1:0]   forwardB,
   input  logic [N-1:0] aluRes_fwd,
   input  logic [N-1:0] muxOut_fwd,
   output logic [N-1:0] ALUres,
   output logic [N-1:0] wrData,
   output logic [N-1:0] ImmOUT,
   output logic [N-1:0] jPC,
   output logic [N-1:0] NPC4_OUT,
   output logic         PC_sel,
   output logic [6:0]   cwMEM,
   output logic [4:0]   Rdest,
   output logic         ex_busy
);

   logic [N-1:0]        fa, fb, op_a, op_b, alu_res, md_res, res_p0, jpc_p0;
   logic signed [N-1:0] fa_s, fb_s;
   logic [2:0]          br_code;
   logic                taken, pc_sel_p0, md_done;
   logic [5*N-1:0]      data_p0, data_p1;
   logic [12:0]         ctrl_p0, ctrl_p1;

   function automatic logic [N-1:0] fwd_sel(input logic [1:0] sel, input logic [N-1:0] rf,
                                            input logic [N-1:0] mux_v, input logic [N-1:0] alu_v);
      case (sel)
         FWD_MUX: return mux_v;
         FWD_ALU: return alu_v;
         default: return rf;
      endcase
   endfunction

   assign fa      = fwd_sel(forwardA, r1, muxOut_fwd, aluRes_fwd);
   assign fb      = fwd_sel(forwardB, r2, muxOut_fwd, aluRes_fwd);
   assign fa_s    = fa;
   assign fb_s    = fb;
   assign op_a    = cwEX[CW_SELA] ? fa : NPCin;
   assign op_b    = cwEX[CW_SELB] ? Imm : fb;
   assign br_code = cwEX[CW_BR_HI:CW_BR_LO];

   always_comb begin
      taken = 1'b0;
      case (br_code)
         BR_EQ:   taken = (fa == fb);
         BR_NE:   taken = (fa != fb);
         BR_LE:   taken = (fa_s <= fb_s);
         BR_LT:   taken = (fa_s < fb_s);
         BR_GE:   taken = (fa_s >= fb_s);
         BR_LTU:  taken = (fa < fb);
         BR_GEU:  taken = (fa >= fb);
         default: taken = 1'b0;
      endcase
   end

   // branch codes carry no meaning on an M-type instruction
   assign pc_sel_p0 = (taken & (br_code != BR_NONE) & ~md_valid) | cwEX[CW_JMP];
   assign jpc_p0    = NPCin - N'(4) + (Imm << 1);

   ALU #(.N(N)) u_alu (
      .op  (aluOp),
      .a   (op_a),
      .b   (op_b),
      .res (alu_res)
   );

   muldiv_iter #(.N(N), .MD_CNT_W(MD_CNT_W)) u_md (
      .clk     (clk),
      .rst     (rst),
      .start   (md_valid),
      .pipe_en (pipe_en),
      .op      (mdOp),
      .a       (fa),
      .b       (fb),
      .done    (md_done),
      .result  (md_res)
   );

   assign ex_busy = md_valid & ~md_done;
   assign res_p0  = md_valid ? md_res : alu_res;
   assign data_p0 = {res_p0, fb, Imm, jpc_p0, NPC4_IN};
   assign ctrl_p0 = ex_busy ? '0 : {pc_sel_p0, cwEX[CW_MEM_HI:0], Rdest_in};

   // EX/MEM boundary: data holds across a stall, control takes a bubble
   register_generic #(.W(5*N)) u_exmem_data (
      .clk (clk),
      .rst (rst),
      .en  (pipe_en & ~ex_busy),
      .d   (data_p0),
      .q   (data_p1)
   );

   register_generic #(.W(13)) u_exmem_ctrl (
      .clk (clk),
      .rst (rst),
      .en  (pipe_en),
      .d   (ctrl_p0),
      .q   (ctrl_p1)
   );

   assign {ALUres, wrData, ImmOUT, jPC, NPC4_OUT} = data_p1;
   assign {PC_sel, cwMEM, Rdest}                  = ctrl_p1;

endmodule

// File: tb/tb_execute_md.sv
// Directed bench for execute_md: reset, branches, forwarding, RV32M ops,
// special cases, pipe_en stall and reset during an iterative operation.
module tb_execute_md;
   import exe_pkg::*;

   localparam int N = 32;
`ifdef EXE_FAST_MUL_EN
   localparam int MUL_BUSY = 1;
`else
   localparam int MUL_BUSY = N + 1;
`endif
   localparam int DIV_BUSY = N + 1;

   logic         clk, rst, pipe_en, md_valid;
   logic [12:0]  cwEX;
   logic [3:0]   aluOp;
   logic [2:0]   mdOp;
   logic [4:0]   Rdest_in;
   logic [N-1:0] NPCin, NPC4_IN, r1, r2, Imm, aluRes_fwd, muxOut_fwd;
   logic [1:0]   forwardA, forwardB;
   logic [N-1:0] ALUres, wrData, ImmOUT, jPC, NPC4_OUT;
   logic         PC_sel;
   logic [6:0]   cwMEM;
   logic [4:0]   Rdest;
   logic         ex_busy;
   int           total, bad;

   execute_md #(.N(N)) dut (
      .clk(clk), .rst(rst), .pipe_en(pipe_en), .cwEX(cwEX), .aluOp(aluOp),
      .md_valid(md_valid), .mdOp(mdOp), .Rdest_in(Rdest_in), .NPCin(NPCin),
      .NPC4_IN(NPC4_IN), .r1(r1), .r2(r2), .Imm(Imm), .forwardA(forwardA),
      .forwardB(forwardB), .aluRes_fwd(aluRes_fwd), .muxOut_fwd(muxOut_fwd),
      .ALUres(ALUres), .wrData(wrData), .ImmOUT(ImmOUT), .jPC(jPC),
      .NPC4_OUT(NPC4_OUT), .PC_sel(PC_sel), .cwMEM(cwMEM), .Rdest(Rdest),
      .ex_busy(ex_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [12:0] cw(input logic selb, input logic sela, input logic [2:0] br,
                                      input logic jmp, input logic [6:0] mem);
      return {selb, sela, br, jmp, mem};
   endfunction

   // issue one M-type op and follow it until the result lands in EX/MEM
   task automatic run_md(input string tag, input md_op_e op, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic [N-1:0] exp_res, input int exp_busy);
      int n, bub;
      mdOp = op; r1 = a; r2 = b; forwardA = FWD_REG; forwardB = FWD_REG;
      cwEX = cw(1'b0, 1'b1, BR_NONE, 1'b0, 7'h21); Rdest_in = 5'd9; md_valid = 1'b1;
      #1;
      n = 0; bub = 0;
      while (ex_busy && n < 100) begin
         tick();
         n++;
         if (cwMEM !== 7'h0 || Rdest !== 5'h0 || PC_sel !== 1'b0) bub++;
      end
      chk({tag, "_busy"}, 32'(n), 32'(exp_busy));
      chk({tag, "_bubbles"}, 32'(bub), 32'(0));
      tick();
      chk({tag, "_res"}, ALUres, exp_res);
      chk({tag, "_cw"}, 32'(cwMEM), 32'(7'h21));
      md_valid = 1'b0;
   endtask

   initial begin
      int n;
      total = 0; bad = 0;
      rst = 1'b0; pipe_en = 1'b1; md_valid = 1'b0; cwEX = '0; aluOp = ALU_ADD;
      mdOp = '0; Rdest_in = '0; NPCin = '0; NPC4_IN = '0; r1 = '0; r2 = '0; Imm = '0;
      forwardA = '0; forwardB = '0; aluRes_fwd = '0; muxOut_fwd = '0;

      // reset state
      tick(); tick();
      chk("rst_alures", ALUres, 32'h0);
      chk("rst_jpc", jPC, 32'h0);
      chk("rst_ctrl", {18'h0, PC_sel, cwMEM, Rdest}, 32'h0);
      chk("rst_busy0", 32'(ex_busy), 32'h0);
      md_valid = 1'b1; #1;
      chk("rst_busy1", 32'(ex_busy), 32'h1);
      md_valid = 1'b0;
      rst = 1'b1;

      // BEQ taken: target = NPCin - 4 + (Imm << 1)
      cwEX = cw(1'b0, 1'b1, BR_EQ, 1'b0, 7'h15); aluOp = ALU_ADD;
      r1 = 5; r2 = 5; NPCin = 32'h104; NPC4_IN = 32'h108; Imm = 32'h10; Rdest_in = 5'd3;
      tick();
      chk("beq_pcsel", 32'(PC_sel), 32'h1);
      chk("beq_jpc", jPC, 32'h120);
      chk("beq_alures", ALUres, 32'd10);
      chk("beq_cwmem", 32'(cwMEM), 32'h15);
      chk("beq_rdest", 32'(Rdest), 32'd3);
      chk("beq_wrdata", wrData, 32'd5);
      chk("beq_imm", ImmOUT, 32'h10);
      chk("beq_npc4", NPC4_OUT, 32'h108);

      cwEX = cw(1'b0, 1'b1, BR_NE, 1'b0, 7'h15); tick();
      chk("bne_eq", 32'(PC_sel), 32'h0);
      r1 = 32'hFFFF_FFFF; r2 = 1;
      cwEX = cw(1'b0, 1'b1, BR_LT, 1'b0, 7'h15); tick();
      chk("blt_signed", 32'(PC_sel), 32'h1);
      cwEX = cw(1'b0, 1'b1, BR_LTU, 1'b0, 7'h15); tick();
      chk("bltu", 32'(PC_sel), 32'h0);
      cwEX = cw(1'b0, 1'b1, BR_GE, 1'b0, 7'h15); tick();
      chk("bge", 32'(PC_sel), 32'h0);
      cwEX = cw(1'b0, 1'b1, BR_GEU, 1'b0, 7'h15); tick();
      chk("bgeu", 32'(PC_sel), 32'h1);
      cwEX = cw(1'b0, 1'b1, BR_LE, 1'b0, 7'h15); tick();
      chk("ble", 32'(PC_sel), 32'h1);
      cwEX = cw(1'b0, 1'b1, BR_NONE, 1'b1, 7'h15); tick();
      chk("jmp", 32'(PC_sel), 32'h1);
      cwEX = cw(1'b0, 1'b1, BR_NONE, 1'b0, 7'h15); tick();
      chk("no_branch", 32'(PC_sel), 32'h0);

      // forwarding into the ALU and the store data path
      forwardA = FWD_ALU; aluRes_fwd = 7; r1 = 3; r2 = 1; tick();
      chk("fwdA_alu", ALUres, 32'd8);
      forwardA = FWD_MUX; muxOut_fwd = 100; forwardB = FWD_ALU; tick();
      chk("fwdAB", ALUres, 32'd107);
      chk("fwdB_wrdata", wrData, 32'd7);
      forwardA = 2'b11; forwardB = 2'b11; aluOp = ALU_SUB; tick();
      chk("fwd11_sub", ALUres, 32'd2);
      forwardA = FWD_REG; forwardB = FWD_REG; aluOp = ALU_ADD;
      cwEX = cw(1'b1, 1'b0, BR_NONE, 1'b0, 7'h15); NPCin = 32'h200; Imm = 32'h30; tick();
      chk("npc_plus_imm", ALUres, 32'h230);

      pipe_en = 1'b0; Imm = 32'h40; tick();
      chk("pipe_hold", ALUres, 32'h230);
      pipe_en = 1'b1;

      // RV32M
      run_md("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_BUSY);
      run_md("rem_neg", MD_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_BUSY);
      run_md("divu_z", MD_DIVU, 32'd10, 32'd0, 32'hFFFF_FFFF, DIV_BUSY);
      run_md("remu_z", MD_REMU, 32'd10, 32'd0, 32'd10, DIV_BUSY);
      run_md("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, DIV_BUSY);
      run_md("rem_ovf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, DIV_BUSY);
      run_md("div_z_neg", MD_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, DIV_BUSY);
      run_md("div_pos_neg", MD_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_BUSY);
      run_md("rem_pos_neg", MD_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, DIV_BUSY);
      run_md("mulhu", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_BUSY);
      run_md("mul", MD_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_BUSY);
      run_md("mulh", MD_MULH, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, MUL_BUSY);
      run_md("mulhsu", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_BUSY);
      run_md("mulh_big", MD_MULH, 32'h4000_0000, 32'h0000_0008, 32'h0000_0002, MUL_BUSY);

      // pipe_en low: iteration continues, DONE is held, EX/MEM untouched
      pipe_en = 1'b0;
      mdOp = MD_DIVU; r1 = 100; r2 = 7; md_valid = 1'b1; #1;
      n = 0;
      while (ex_busy && n < 100) begin
         tick();
         n++;
      end
      chk("stall_busy", 32'(n), 32'(DIV_BUSY));
      tick(); tick();
      chk("stall_hold_busy", 32'(ex_busy), 32'h0);
      chk("stall_hold_res", ALUres, 32'h0000_0002);
      chk("stall_hold_cw", 32'(cwMEM), 32'h21);
      pipe_en = 1'b1; tick();
      chk("stall_release", ALUres, 32'd14);
      md_valid = 1'b0;

      // reset during BUSY, then a full restart with md_valid held
      mdOp = MD_DIVU; r1 = 100; r2 = 7; md_valid = 1'b1;
      for (int i = 0; i < 11; i++) tick();
      rst = 1'b0; #1;
      chk("mid_rst_alures", ALUres, 32'h0);
      chk("mid_rst_wrdata", wrData, 32'h0);
      chk("mid_rst_ctrl", {18'h0, PC_sel, cwMEM, Rdest}, 32'h0);
      chk("mid_rst_busy", 32'(ex_busy), 32'h1);
      tick();
      rst = 1'b1;
      run_md("restart", MD_DIVU, 32'd100, 32'd7, 32'd14, DIV_BUSY);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
